id_ex_stage: RTL and testbench

Pipeline register between decode and execute for the 5-stage RV32I core, with load-use hazard detection. It latches decoded operands, register indices and control bits every cycle. The registered `ex_rs1_idx`, `ex_rs2_idx` and data feed the forwarding unit and the ALU operand muxes. When a load in EX is followed by a dependent instruction in ID, it stalls PC and IF/ID for one cycle and inserts a bubble into EX. A taken-branch flush from later stages overrides the stall.

---
 rtl/id_ex_stage_if.sv | 47 ++++
 rtl/id_ex_stage.sv | 98 +++++++++
 tb/tb_id_ex_stage.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bus: ID-side operands/control in, EX-side registered copies
// plus load-use stall controls out. The master side drives ID, the slave is the stage.
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int CNT_W  = 16
);
    logic [PC_W-1:0]   id_pc;
    logic [DATA_W-1:0] id_rs1_data;
    logic [DATA_W-1:0] id_rs2_data;
    logic [DATA_W-1:0] id_imm;
    logic [4:0]        id_rs1_idx;
    logic [4:0]        id_rs2_idx;
    logic [4:0]        id_rd_idx;
    logic [8:0]        id_ctrl;
    logic [2:0]        id_funct3;
    logic              flush;

    logic [PC_W-1:0]   ex_pc;
    logic [DATA_W-1:0] ex_rs1_data;
    logic [DATA_W-1:0] ex_rs2_data;
    logic [DATA_W-1:0] ex_imm;
    logic [4:0]        ex_rs1_idx;
    logic [4:0]        ex_rs2_idx;
    logic [4:0]        ex_rd_idx;
    logic [8:0]        ex_ctrl;
    logic [2:0]        ex_funct3;
    logic              pc_write;
    logic              ifid_write;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_pc, id_rs1_data, id_rs2_data, id_imm,
        output id_rs1_idx, id_rs2_idx, id_rd_idx, id_ctrl, id_funct3, flush,
        input  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
        input  ex_rs1_idx, ex_rs2_idx, ex_rd_idx, ex_ctrl, ex_funct3,
        input  pc_write, ifid_write, stall_cnt
    );

    modport slave (
        input  id_pc, id_rs1_data, id_rs2_data, id_imm,
        input  id_rs1_idx, id_rs2_idx, id_rd_idx, id_ctrl, id_funct3, flush,
        output ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
        output ex_rs1_idx, ex_rs2_idx, ex_rd_idx, ex_ctrl, ex_funct3,
        output pc_write, ifid_write, stall_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection for the RV32I core.
// Define LOAD_USE_DETECT_EN to enable stall generation and the stall counter.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int CNT_W  = 16
) (
    input logic          clk,
    input logic          rst_n,
    id_ex_stage_if.slave bus
);

    localparam int MEM_READ_BIT = 7;

    logic [PC_W-1:0]   ex_pc_q,       ex_pc_d;
    logic [DATA_W-1:0] ex_rs1_data_q, ex_rs1_data_d;
    logic [DATA_W-1:0] ex_rs2_data_q, ex_rs2_data_d;
    logic [DATA_W-1:0] ex_imm_q,      ex_imm_d;
    logic [4:0]        ex_rs1_idx_q,  ex_rs1_idx_d;
    logic [4:0]        ex_rs2_idx_q,  ex_rs2_idx_d;
    logic [4:0]        ex_rd_idx_q,   ex_rd_idx_d;
    logic [8:0]        ex_ctrl_q,     ex_ctrl_d;
    logic [2:0]        ex_funct3_q,   ex_funct3_d;
    logic [CNT_W-1:0]  stall_cnt_q,   stall_cnt_d;
    logic              hazard;
    logic              stall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Hazard is evaluated from registered EX state against live ID indices.
    always_comb begin
        hazard = 1'b0;
`ifdef LOAD_USE_DETECT_EN
        hazard = ex_ctrl_q[MEM_READ_BIT] && (ex_rd_idx_q != 5'd0) &&
                 ((ex_rd_idx_q == bus.id_rs1_idx) || (ex_rd_idx_q == bus.id_rs2_idx));
`endif
        stall = hazard && !bus.flush;
    end

    always_comb begin
        ex_pc_d       = bus.id_pc;
        ex_rs1_data_d = bus.id_rs1_data;
        ex_rs2_data_d = bus.id_rs2_data;
        ex_imm_d      = bus.id_imm;
        ex_rs1_idx_d  = bus.id_rs1_idx;
        ex_rs2_idx_d  = bus.id_rs2_idx;
        ex_rd_idx_d   = bus.id_rd_idx;
        ex_funct3_d   = bus.id_funct3;
        ex_ctrl_d     = (bus.flush || hazard) ? 9'd0 : bus.id_ctrl;
`ifdef LOAD_USE_DETECT_EN
        stall_cnt_d   = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
`else
        stall_cnt_d   = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_pc_q       <= '0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_imm_q      <= '0;
            ex_rs1_idx_q  <= '0;
            ex_rs2_idx_q  <= '0;
            ex_rd_idx_q   <= '0;
            ex_ctrl_q     <= '0;
            ex_funct3_q   <= '0;
            stall_cnt_q   <= '0;
        end else begin
            ex_pc_q       <= ex_pc_d;
            ex_rs1_data_q <= ex_rs1_data_d;
            ex_rs2_data_q <= ex_rs2_data_d;
            ex_imm_q      <= ex_imm_d;
            ex_rs1_idx_q  <= ex_rs1_idx_d;
            ex_rs2_idx_q  <= ex_rs2_idx_d;
            ex_rd_idx_q   <= ex_rd_idx_d;
            ex_ctrl_q     <= ex_ctrl_d;
            ex_funct3_q   <= ex_funct3_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign bus.ex_pc       = ex_pc_q;
    assign bus.ex_rs1_data = ex_rs1_data_q;
    assign bus.ex_rs2_data = ex_rs2_data_q;
    assign bus.ex_imm      = ex_imm_q;
    assign bus.ex_rs1_idx  = ex_rs1_idx_q;
    assign bus.ex_rs2_idx  = ex_rs2_idx_q;
    assign bus.ex_rd_idx   = ex_rd_idx_q;
    assign bus.ex_ctrl     = ex_ctrl_q;
    assign bus.ex_funct3   = ex_funct3_q;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.pc_write    = !stall;
    assign bus.ifid_write  = !stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector bench for id_ex_stage (CNT_W = 4 so counter saturation is reachable).
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int PC_W   = 32;
    localparam int CNT_W  = 4;

    localparam logic [8:0] LW_CTRL  = 9'h1B0;
    localparam logic [8:0] ADD_CTRL = 9'h104;

`ifdef LOAD_USE_DETECT_EN
    localparam bit DET = 1'b1;
`else
    localparam bit DET = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    id_ex_stage_if #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    id_ex_stage #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [8:0] ctrl;
        logic       flush;
        logic       pcw_det;
        logic [3:0] cnt_det;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [8:0] ctrl, input logic fl, input int i);
        bus.id_rs1_idx  = rs1;
        bus.id_rs2_idx  = rs2;
        bus.id_rd_idx   = rd;
        bus.id_ctrl     = ctrl;
        bus.flush       = fl;
        bus.id_pc       = 32'h100 + 32'(i) * 4;
        bus.id_rs1_data = 32'hA000_0000 | 32'(i);
        bus.id_rs2_data = 32'h5000_0000 + 32'(i);
        bus.id_imm      = 32'hFFFF_FFF0 + 32'(i);
        bus.id_funct3   = 3'(i);
    endtask

    task automatic check_zero_state(input string tag);
        check({tag, " ex_ctrl"},    32'(bus.ex_ctrl), 32'd0);
        check({tag, " ex_pc"},      bus.ex_pc, 32'd0);
        check({tag, " ex_rs1_data"}, bus.ex_rs1_data, 32'd0);
        check({tag, " ex_imm"},     bus.ex_imm, 32'd0);
        check({tag, " ex_rd_idx"},  32'(bus.ex_rd_idx), 32'd0);
        check({tag, " ex_rs1_idx"}, 32'(bus.ex_rs1_idx), 32'd0);
        check({tag, " stall_cnt"},  32'(bus.stall_cnt), 32'd0);
        check({tag, " pc_write"},   32'(bus.pc_write), 32'd1);
        check({tag, " ifid_write"}, 32'(bus.ifid_write), 32'd1);
    endtask

    initial begin
        int stalls_seen;
        logic [8:0] exp_ctrl;
        logic       exp_pcw;
        logic [3:0] exp_cnt;

        n_checks = 0;
        n_fail   = 0;

        //           rs1    rs2    rd     ctrl      flush pcw_det cnt_det
        vecs[0]  = '{5'd1, 5'd0, 5'd5, LW_CTRL,  1'b0, 1'b1, 4'd0}; // lw  x5,0(x1)
        vecs[1]  = '{5'd5, 5'd7, 5'd6, ADD_CTRL, 1'b0, 1'b0, 4'd1}; // add x6,x5,x7 -> stall
        vecs[2]  = '{5'd5, 5'd7, 5'd6, ADD_CTRL, 1'b0, 1'b1, 4'd1}; // add replayed
        vecs[3]  = '{5'd1, 5'd0, 5'd0, LW_CTRL,  1'b0, 1'b1, 4'd1}; // lw  x0,0(x1)
        vecs[4]  = '{5'd0, 5'd7, 5'd6, ADD_CTRL, 1'b0, 1'b1, 4'd1}; // add x6,x0,x7 no stall
        vecs[5]  = '{5'd1, 5'd0, 5'd5, LW_CTRL,  1'b0, 1'b1, 4'd1}; // lw  x5,0(x1)
        vecs[6]  = '{5'd3, 5'd5, 5'd6, ADD_CTRL, 1'b1, 1'b1, 4'd1}; // dependent + flush
        vecs[7]  = '{5'd2, 5'd0, 5'd5, LW_CTRL,  1'b0, 1'b1, 4'd1}; // lw  x5,0(x2)
        vecs[8]  = '{5'd5, 5'd4, 5'd8, LW_CTRL,  1'b0, 1'b0, 4'd2}; // lw  x8,4(x5) -> stall
        vecs[9]  = '{5'd5, 5'd4, 5'd8, LW_CTRL,  1'b0, 1'b1, 4'd2}; // lw  x8 enters EX
        vecs[10] = '{5'd1, 5'd8, 5'd9, ADD_CTRL, 1'b0, 1'b0, 4'd3}; // add x9,x1,x8 -> stall
        vecs[11] = '{5'd1, 5'd8, 5'd9, ADD_CTRL, 1'b0, 1'b1, 4'd3}; // add enters EX
        vecs[12] = '{5'd1, 5'd2, 5'd3, 9'h1FF,   1'b1, 1'b1, 4'd3}; // plain flush

        // Power-on reset with busy ID inputs.
        rst_n = 1'b0;
        drive(5'd5, 5'd5, 5'd5, 9'h1FF, 1'b0, 7);
        repeat (2) @(posedge clk);
        #1 check_zero_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].ctrl, vecs[i].flush, i);
            exp_pcw  = DET ? vecs[i].pcw_det : 1'b1;
            exp_ctrl = (vecs[i].flush || !exp_pcw) ? 9'd0 : vecs[i].ctrl;
            exp_cnt  = DET ? vecs[i].cnt_det : 4'd0;
            #1;
            check($sformatf("v%0d pc_write", i),   32'(bus.pc_write),   32'(exp_pcw));
            check($sformatf("v%0d ifid_write", i), 32'(bus.ifid_write), 32'(exp_pcw));
            @(posedge clk);
            #1;
            check($sformatf("v%0d ex_ctrl", i),     32'(bus.ex_ctrl),    32'(exp_ctrl));
            check($sformatf("v%0d ex_rs1_idx", i),  32'(bus.ex_rs1_idx), 32'(vecs[i].rs1));
            check($sformatf("v%0d ex_rs2_idx", i),  32'(bus.ex_rs2_idx), 32'(vecs[i].rs2));
            check($sformatf("v%0d ex_rd_idx", i),   32'(bus.ex_rd_idx),  32'(vecs[i].rd));
            check($sformatf("v%0d ex_pc", i),       bus.ex_pc,           32'h100 + 32'(i) * 4);
            check($sformatf("v%0d ex_rs1_data", i), bus.ex_rs1_data,     32'hA000_0000 | 32'(i));
            check($sformatf("v%0d ex_rs2_data", i), bus.ex_rs2_data,     32'h5000_0000 + 32'(i));
            check($sformatf("v%0d ex_imm", i),      bus.ex_imm,          32'hFFFF_FFF0 + 32'(i));
            check($sformatf("v%0d ex_funct3", i),   32'(bus.ex_funct3),  32'(i % 8));
            check($sformatf("v%0d stall_cnt", i),   32'(bus.stall_cnt),  32'(exp_cnt));
            @(negedge clk);
        end

        // 20 load-use pairs: counter starts at 3 and must stop at 15.
        stalls_seen = 0;
        for (int p = 0; p < 20; p++) begin
            drive(5'd1, 5'd0, 5'd5, LW_CTRL, 1'b0, 20);
            @(negedge clk);
            drive(5'd5, 5'd7, 5'd6, ADD_CTRL, 1'b0, 21);
            #1;
            if (!bus.pc_write) stalls_seen++;
            @(negedge clk);
            #1;
            if (!bus.pc_write) stalls_seen++;
            @(negedge clk);
            if (p == 11)
                check("sat reach 15", 32'(bus.stall_cnt), DET ? 32'd15 : 32'd0);
        end
        check("sat stall cycles", 32'(stalls_seen), DET ? 32'd20 : 32'd0);
        check("sat stall_cnt",    32'(bus.stall_cnt), DET ? 32'd15 : 32'd0);

        // Asynchronous reset asserted in the middle of a stall.
        drive(5'd1, 5'd0, 5'd5, 9'h1FF, 1'b0, 30);
        @(posedge clk);
        #1;
        drive(5'd5, 5'd0, 5'd6, ADD_CTRL, 1'b0, 31);
        #1;
        check("midstall ex_ctrl",  32'(bus.ex_ctrl),  32'h1FF);
        check("midstall pc_write", 32'(bus.pc_write), DET ? 32'd0 : 32'd1);
        #1 rst_n = 1'b0;
        #1 check_zero_state("async rst");
        @(posedge clk);
        #1 check("rst held ex_ctrl", 32'(bus.ex_ctrl), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("post rst pc_write", 32'(bus.pc_write), 32'd1);
        @(posedge clk);
        #1;
        check("post rst ex_ctrl",    32'(bus.ex_ctrl),    32'(ADD_CTRL));
        check("post rst ex_rs1_idx", 32'(bus.ex_rs1_idx), 32'd5);
        check("post rst stall_cnt",  32'(bus.stall_cnt),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
